// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
// Pure wiring with no latency and no storage; the channel VALID/READY pairs carry the backpressure.
interface axi4lite #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = 4
);
    logic                      AW_VALID;
    logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
    logic [2:0]                AW_PROT;
    logic                      AW_READY;
    logic                      W_VALID;
    logic [AXI_DATA_WIDTH-1:0] W_DATA;
    logic [AXI_STRB_WIDTH-1:0] W_STRB;
    logic                      W_READY;
    logic                      B_VALID;
    logic [1:0]                B_RESP;
    logic                      B_READY;
    logic                      AR_VALID;
    logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
    logic [2:0]                AR_PROT;
    logic                      AR_READY;
    logic                      R_VALID;
    logic [AXI_DATA_WIDTH-1:0] R_DATA;
    logic [1:0]                R_RESP;
    logic                      R_READY;

    modport master (
        output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register file: reg 0 is a read-only ID, regs 1..NUM_REGS-1 are byte-strobed RW.
// Write commits on the second AW/W handshake with B the same edge; read data is 1 cycle after AR.
// B and R hold until READY; no new AW/W in W_RESP, no AR in R_RESP. AXI_SLV_PROT_CHECK_EN rejects PROT[0]=0.
module axi4lite_slave_regs #(
    parameter int          NUM_REGS       = 8,
    parameter logic [31:0] ID_VALUE       = 32'hA41E_0001,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_STRB_WIDTH = 4
) (
    input  logic                             A_CLK,
    input  logic                             A_RSTn,
    axi4lite.slave                           s_axi,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REGS_Q
);
    localparam int         IDX_W       = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP} rstate_t;

    wstate_t                   r_wstate, w_wstate_nxt;
    rstate_t                   r_rstate, w_rstate_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic [2:0]                r_aw_prot;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [AXI_STRB_WIDTH-1:0] r_w_strb;
    logic [1:0]                r_bresp;
    logic [1:0]                r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                      w_commit, w_ar_hs;
    logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
    logic [2:0]                w_wr_prot;
    logic [AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [AXI_STRB_WIDTH-1:0] w_wr_strb;
    logic [IDX_W-1:0]          w_wr_idx, w_rd_idx;
    logic                      w_wr_priv, w_rd_priv, w_wr_ok, w_rd_ok;
    logic                      w_unused;

    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    // Whichever half arrived first is held; the other comes straight off the bus.
    assign w_wr_addr = (r_wstate == W_ADDR) ? r_aw_addr : s_axi.AW_ADDR;
    assign w_wr_prot = (r_wstate == W_ADDR) ? r_aw_prot : s_axi.AW_PROT;
    assign w_wr_data = (r_wstate == W_DATA) ? r_w_data  : s_axi.W_DATA;
    assign w_wr_strb = (r_wstate == W_DATA) ? r_w_strb  : s_axi.W_STRB;
    assign w_wr_idx  = w_wr_addr[IDX_W+1:2];
    assign w_rd_idx  = s_axi.AR_ADDR[IDX_W+1:2];

`ifdef AXI_SLV_PROT_CHECK_EN
    assign w_wr_priv = w_wr_prot[0];
    assign w_rd_priv = s_axi.AR_PROT[0];
    assign w_unused  = ^{w_wr_prot[2:1], s_axi.AR_PROT[2:1]};
`else
    assign w_wr_priv = 1'b1;
    assign w_rd_priv = 1'b1;
    assign w_unused  = ^{w_wr_prot, s_axi.AR_PROT};
`endif

    assign w_wr_ok = in_range(w_wr_addr) && (w_wr_idx != '0) && w_wr_priv;
    assign w_rd_ok = in_range(s_axi.AR_ADDR) && w_rd_priv;

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_commit       = 1'b0;
        s_axi.AW_READY = (r_wstate == W_IDLE) || (r_wstate == W_DATA);
        s_axi.W_READY  = (r_wstate == W_IDLE) || (r_wstate == W_ADDR);
        s_axi.B_VALID  = (r_wstate == W_RESP);
        case (r_wstate)
            W_IDLE: begin
                if (s_axi.AW_VALID && s_axi.W_VALID) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (s_axi.AW_VALID) begin
                    w_wstate_nxt = W_ADDR;
                end else if (s_axi.W_VALID) begin
                    w_wstate_nxt = W_DATA;
                end
            end
            W_ADDR: if (s_axi.W_VALID) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_DATA: if (s_axi.AW_VALID) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_RESP: if (s_axi.B_READY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt   = r_rstate;
        s_axi.AR_READY = (r_rstate == R_IDLE);
        s_axi.R_VALID  = (r_rstate == R_RESP);
        w_ar_hs        = (r_rstate == R_IDLE) && s_axi.AR_VALID;
        case (r_rstate)
            R_IDLE:  if (s_axi.AR_VALID) w_rstate_nxt = R_RESP;
            R_RESP:  if (s_axi.R_READY)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            r_aw_addr <= '0;
            r_aw_prot <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (s_axi.AW_VALID && s_axi.AW_READY) begin
                r_aw_addr <= s_axi.AW_ADDR;
                r_aw_prot <= s_axi.AW_PROT;
            end
            if (s_axi.W_VALID && s_axi.W_READY) begin
                r_w_data <= s_axi.W_DATA;
                r_w_strb <= s_axi.W_STRB;
            end
            if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int k = 0; k < AXI_STRB_WIDTH; k++) begin
                if (w_wr_strb[k]) r_regs[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
            end
        end
    end

    // Reads sample the array before any same-edge write lands, so they see the old value.
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            if (!w_rd_ok) begin
                r_rdata <= '0;
                r_rresp <= RESP_SLVERR;
            end else begin
                r_rdata <= (w_rd_idx == '0) ? ID_VALUE : r_regs[w_rd_idx];
                r_rresp <= RESP_OKAY;
            end
        end
    end

    assign s_axi.B_RESP = r_bresp;
    assign s_axi.R_DATA = r_rdata;
    assign s_axi.R_RESP = r_rresp;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_q
        assign REGS_Q[AXI_DATA_WIDTH*gi +: AXI_DATA_WIDTH] = r_regs[gi];
    end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Bench for axi4lite_slave_regs: vector table of reads/writes plus hand-built stall, reset and collision sequences.
module tb_axi4lite_slave_regs;
    localparam int         NUM_REGS = 8;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    logic                   A_CLK  = 1'b0;
    logic                   A_RSTn = 1'b0;
    logic [NUM_REGS*32-1:0] regs_q;

    axi4lite #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_STRB_WIDTH(4)) bus ();

    axi4lite_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VALUE(32'hA41E_0001)) dut (
        .A_CLK  (A_CLK),
        .A_RSTn (A_RSTn),
        .s_axi  (bus.slave),
        .REGS_Q (regs_q)
    );

    always #5 A_CLK = ~A_CLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [NUM_REGS];
    logic [1:0]  wq [$];
    rexp_t       rq [$];
    vec_t        vecs [17];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_q();
        logic [255:0] q = '0;
        for (int i = 0; i < NUM_REGS; i++) q[32*i +: 32] = m_regs[i];
        return q;
    endfunction

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    // lead > 0: W is offered lead cycles before AW; lead < 0: AW leads.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int lead, input logic [1:0] exp_resp);
        bit         aw_done = 0, w_done = 0, aw_hs, w_hs;
        int         c = 0;
        int         aw_start = (lead > 0) ? lead : 0;
        int         w_start  = (lead < 0) ? -lead : 0;
        logic [1:0] e;
        wq.push_back(exp_resp);
        bus.AW_ADDR = addr;
        bus.AW_PROT = prot;
        bus.W_DATA  = data;
        bus.W_STRB  = strb;
        while (!(aw_done && w_done) && c < 40) begin
            bus.AW_VALID = !aw_done && (c >= aw_start);
            bus.W_VALID  = !w_done && (c >= w_start);
            aw_hs = bus.AW_VALID && bus.AW_READY;
            w_hs  = bus.W_VALID && bus.W_READY;
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            c++;
        end
        bus.AW_VALID = 1'b0;
        bus.W_VALID  = 1'b0;
        check("wr_handshakes_done", aw_done && w_done, 1);
        check("b_valid_on_commit", bus.B_VALID, 1);
        bus.B_READY = 1'b1;
        c = 0;
        while (!bus.B_VALID && c < 40) begin
            tick();
            c++;
        end
        e = wq.pop_front();
        check("b_resp", bus.B_RESP, e);
        tick();
        bus.B_READY = 1'b0;
        if (exp_resp == OKAY) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) m_regs[addr[4:2]][8*k +: 8] = data[8*k +: 8];
        end
        check("regs_q_after_write", regs_q, model_q());
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        rexp_t e;
        bit    rdy = 0;
        int    c = 0;
        e.data = exp_data;
        e.resp = exp_resp;
        rq.push_back(e);
        bus.AR_ADDR  = addr;
        bus.AR_PROT  = prot;
        bus.AR_VALID = 1'b1;
        while (!rdy && c < 40) begin
            rdy = bus.AR_READY;
            tick();
            c++;
        end
        bus.AR_VALID = 1'b0;
        check("ar_handshake_done", rdy, 1);
        check("r_valid_latency1", bus.R_VALID, 1);
        check("ar_ready_busy", bus.AR_READY, 0);
        tick();
        check("r_valid_held", bus.R_VALID, 1);
        bus.R_READY = 1'b1;
        e = rq.pop_front();
        check("r_data", bus.R_DATA, e.data);
        check("r_resp", bus.R_RESP, e.resp);
        tick();
        bus.R_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h04,        32'hDEADBEEF, 4'hF, 0,  OKAY,   32'h0};
        vecs[1]  = '{1'b0, 32'h04,        32'h0,        4'h0, 0,  OKAY,   32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h08,        32'h11223344, 4'h5, 3,  OKAY,   32'h0};
        vecs[3]  = '{1'b0, 32'h08,        32'h0,        4'h0, 0,  OKAY,   32'h00220044};
        vecs[4]  = '{1'b1, 32'h00,        32'h12345678, 4'hF, 0,  SLVERR, 32'h0};
        vecs[5]  = '{1'b1, 32'h20,        32'h55555555, 4'hF, 0,  SLVERR, 32'h0};
        vecs[6]  = '{1'b0, 32'h00,        32'h0,        4'h0, 0,  OKAY,   32'hA41E0001};
        vecs[7]  = '{1'b0, 32'h20,        32'h0,        4'h0, 0,  SLVERR, 32'h0};
        vecs[8]  = '{1'b1, 32'h1C,        32'hA5A5A5A5, 4'h8, -2, OKAY,   32'h0};
        vecs[9]  = '{1'b0, 32'h1F,        32'h0,        4'h0, 0,  OKAY,   32'hA5000000};
        vecs[10] = '{1'b1, 32'h0D,        32'hCAFEF00D, 4'h3, 1,  OKAY,   32'h0};
        vecs[11] = '{1'b0, 32'h0C,        32'h0,        4'h0, 0,  OKAY,   32'h0000F00D};
        vecs[12] = '{1'b0, 32'h40,        32'h0,        4'h0, 0,  SLVERR, 32'h0};
        vecs[13] = '{1'b1, 32'h04,        32'h00000000, 4'h0, 0,  OKAY,   32'h0};
        vecs[14] = '{1'b0, 32'h04,        32'h0,        4'h0, 0,  OKAY,   32'hDEADBEEF};
        vecs[15] = '{1'b1, 32'h1000_0004, 32'h77777777, 4'hF, 0,  SLVERR, 32'h0};
        vecs[16] = '{1'b0, 32'h1000_0004, 32'h0,        4'h0, 0,  SLVERR, 32'h0};

        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        bus.AW_VALID = 0; bus.AW_ADDR = '0; bus.AW_PROT = '0;
        bus.W_VALID  = 0; bus.W_DATA  = '0; bus.W_STRB  = '0;
        bus.B_READY  = 0;
        bus.AR_VALID = 0; bus.AR_ADDR = '0; bus.AR_PROT = '0;
        bus.R_READY  = 0;

        repeat (2) tick();
        check("rst_aw_ready", bus.AW_READY, 1);
        check("rst_w_ready", bus.W_READY, 1);
        check("rst_ar_ready", bus.AR_READY, 1);
        check("rst_b_valid", bus.B_VALID, 0);
        check("rst_r_valid", bus.R_VALID, 0);
        check("rst_b_resp", bus.B_RESP, 0);
        check("rst_r_resp", bus.R_RESP, 0);
        check("rst_r_data", bus.R_DATA, 0);
        check("rst_regs_q", regs_q, 0);
        A_RSTn = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 3'b001, vecs[i].lead, vecs[i].resp);
            else
                do_read(vecs[i].addr, 3'b001, vecs[i].rdata, vecs[i].resp);
        end

        // B_READY stalled for 5 cycles while a second write waits on the bus.
        bus.AW_ADDR = 32'h08; bus.AW_PROT = 3'b001;
        bus.W_DATA  = 32'h0BADF00D; bus.W_STRB = 4'hF;
        bus.AW_VALID = 1; bus.W_VALID = 1;
        tick();
        m_regs[2] = 32'h0BADF00D;
        bus.AW_ADDR = 32'h0C;
        bus.W_DATA  = 32'h13579BDF;
        for (int i = 0; i < 5; i++) begin
            check("stall_b_valid", bus.B_VALID, 1);
            check("stall_b_resp", bus.B_RESP, OKAY);
            check("stall_aw_ready", bus.AW_READY, 0);
            check("stall_w_ready", bus.W_READY, 0);
            check("stall_regs_q", regs_q, model_q());
            tick();
        end
        bus.B_READY = 1;
        check("bready_cycle_aw_ready", bus.AW_READY, 0);
        check("bready_cycle_w_ready", bus.W_READY, 0);
        tick();
        bus.B_READY = 0;
        check("post_b_aw_ready", bus.AW_READY, 1);
        check("post_b_w_ready", bus.W_READY, 1);
        check("post_b_b_valid", bus.B_VALID, 0);
        check("post_b_regs_q", regs_q, model_q());
        tick();
        bus.AW_VALID = 0; bus.W_VALID = 0;
        m_regs[3] = 32'h13579BDF;
        check("second_wr_b_valid", bus.B_VALID, 1);
        check("second_wr_b_resp", bus.B_RESP, OKAY);
        check("second_wr_regs_q", regs_q, model_q());
        bus.B_READY = 1;
        tick();
        bus.B_READY = 0;

        // AR on the same edge as a write commit to that register sees the old value.
        do_write(32'h04, 32'h11111111, 4'hF, 3'b001, 0, OKAY);
        bus.AW_ADDR = 32'h04; bus.W_DATA = 32'h22222222; bus.W_STRB = 4'hF;
        bus.AR_ADDR = 32'h04; bus.AR_PROT = 3'b001;
        bus.AW_VALID = 1; bus.W_VALID = 1; bus.AR_VALID = 1;
        tick();
        bus.AW_VALID = 0; bus.W_VALID = 0; bus.AR_VALID = 0;
        m_regs[1] = 32'h22222222;
        check("collide_r_valid", bus.R_VALID, 1);
        check("collide_r_data_old", bus.R_DATA, 32'h11111111);
        check("collide_r_resp", bus.R_RESP, OKAY);
        check("collide_regs_q", regs_q, model_q());
        bus.B_READY = 1; bus.R_READY = 1;
        tick();
        bus.B_READY = 0; bus.R_READY = 0;

        // Reset after only the AW handshake drops the pending write.
        bus.AW_ADDR = 32'h14; bus.AW_PROT = 3'b001; bus.AW_VALID = 1;
        tick();
        bus.AW_VALID = 0;
        check("addr_held_aw_ready", bus.AW_READY, 0);
        check("addr_held_w_ready", bus.W_READY, 1);
        A_RSTn = 0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        check("midrst_aw_ready", bus.AW_READY, 1);
        check("midrst_w_ready", bus.W_READY, 1);
        check("midrst_ar_ready", bus.AR_READY, 1);
        check("midrst_b_valid", bus.B_VALID, 0);
        check("midrst_regs_q", regs_q, model_q());
        tick();
        A_RSTn = 1;
        tick();
        check("postrst_b_valid", bus.B_VALID, 0);
        check("postrst_aw_ready", bus.AW_READY, 1);
        check("postrst_w_ready", bus.W_READY, 1);
        check("postrst_ar_ready", bus.AR_READY, 1);
        bus.W_DATA = 32'hFFFFFFFF; bus.W_STRB = 4'hF; bus.W_VALID = 1;
        tick();
        bus.W_VALID = 0;
        check("postrst_w_only_no_b", bus.B_VALID, 0);
        check("postrst_w_only_regs_q", regs_q, model_q());
        bus.AW_ADDR = 32'h18; bus.AW_VALID = 1;
        tick();
        bus.AW_VALID = 0;
        m_regs[6] = 32'hFFFFFFFF;
        check("postrst_data_first_b_valid", bus.B_VALID, 1);
        check("postrst_data_first_regs_q", regs_q, model_q());
        bus.B_READY = 1;
        tick();
        bus.B_READY = 0;

`ifdef AXI_SLV_PROT_CHECK_EN
        do_write(32'h10, 32'h0F0F0F0F, 4'hF, 3'b000, 0, SLVERR);
        do_read(32'h10, 3'b000, 32'h0, SLVERR);
        do_write(32'h10, 32'h0F0F0F0F, 4'hF, 3'b001, 0, OKAY);
        do_read(32'h10, 3'b001, 32'h0F0F0F0F, OKAY);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
